// File: rtl/coreapb3toahb_master.sv
// APB3 responder to AHB-Lite initiator: each APB access becomes one 32-bit NONSEQ transfer.
// Optional wait-state timeout is enabled by defining COREAPB3TOAHB_TIMEOUT_EN.
module coreapb3toahb_master #(
  parameter int unsigned APB_ADDR_WIDTH = 16,
  parameter logic [31:0] AHB_BASE       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETN,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [31:0]               HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic                      HMASTLOCK,
  output logic [31:0]               HWDATA,
  input  logic [31:0]               HRDATA,
  input  logic                      HREADY,
  input  logic                      HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] prdata_q, prdata_d;
  logic        hwrite_q, hwrite_d;
  logic        err_q, err_d;
  logic        pready_q, pslverr_q;
  logic [31:0] addr_map;
  logic        timeout_hit;

  always_comb begin
    addr_map                     = AHB_BASE;
    addr_map[APB_ADDR_WIDTH-1:0] = PADDR;
    addr_map[1:0]                = 2'b00;
  end

`ifdef COREAPB3TOAHB_TIMEOUT_EN
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  assign waiting     = ((state_q == S_ADDR) || (state_q == S_DATA)) && !HREADY;
  // Fires on the wait cycle that brings the count to the limit.
  assign timeout_hit = waiting && ((cnt_q + CNT_ONE) == CNT_LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          haddr_d  = addr_map;
          hwrite_d = PWRITE;
          if (PWRITE) hwdata_d = PWDATA;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          state_d = S_DATA;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          if (HRESP) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (!hwrite_q) prdata_d = HRDATA;
          end
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // PREADY/PSLVERR are registered from the next state so they are high exactly while in DONE.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q   <= S_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      prdata_q  <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      prdata_q  <= prdata_d;
      err_q     <= err_d;
      pready_q  <= (state_d == S_DONE);
      pslverr_q <= (state_d == S_DONE) && err_d;
    end
  end

  assign HTRANS    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;

endmodule

// File: tb/tb_coreapb3toahb_master.sv
// Self-checking bench for coreapb3toahb_master: table vectors, corner sequences, random accesses.
module tb_coreapb3toahb_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          TO   = 8;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [15:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  int checks = 0, errors = 0, xfers = 0, exp_xfers = 0;
  logic [31:0] model_prdata = '0;

  typedef struct {
    logic        wr;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    int          aw;
    int          dw;
    logic        err;
    logic [31:0] hrdata;
    logic        drop;
    logic [31:0] exp_haddr;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_prdata;
  } vec_t;

  coreapb3toahb_master #(
    .APB_ADDR_WIDTH(16),
    .AHB_BASE      (BASE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Accepted AHB address phases.
  always @(negedge HCLK)
    if (HRESETN && HTRANS == 2'b10 && HREADY) xfers++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_haddr(input logic [15:0] a);
    return (BASE & 32'hFFFF_0000) | ({16'h0, a} & 32'hFFFF_FFFC);
  endfunction

  function automatic vec_t make_vec(input logic wr, input logic [15:0] paddr,
                                    input logic [31:0] pwdata, input int aw, input int dw,
                                    input logic err, input logic [31:0] hrdata, input logic drop);
    vec_t v;
    v.wr = wr; v.paddr = paddr; v.pwdata = pwdata; v.aw = aw; v.dw = dw;
    v.err = err; v.hrdata = hrdata; v.drop = drop;
    v.exp_haddr  = model_haddr(paddr);
    v.exp_lat    = 3 + aw + dw;
    v.exp_err    = err;
    v.exp_prdata = (!wr && !err) ? hrdata : model_prdata;
    return v;
  endfunction

  // Cycle k=0 is the APB setup phase; the AHB slave inserts aw address waits and dw data waits.
  task automatic run_access(input vec_t v);
    for (int k = 0; k <= v.exp_lat; k++) begin
      @(posedge HCLK); #1;
      if (k >= 1 && k <= v.aw + 1) begin
        chk("htrans_nonseq", 32'(HTRANS), 32'h2);
        chk("haddr", HADDR, v.exp_haddr);
        chk("hwrite", 32'(HWRITE), 32'(v.wr));
      end else begin
        chk("htrans_idle", 32'(HTRANS), 32'h0);
      end
      if (v.wr && k >= v.aw + 2 && k <= v.aw + v.dw + 2)
        chk("hwdata", HWDATA, v.pwdata);
      chk("pready", 32'(PREADY), 32'(k == v.exp_lat));
      if (k == v.exp_lat) begin
        chk("pslverr", 32'(PSLVERR), 32'(v.exp_err));
        chk("prdata", PRDATA, v.exp_prdata);
      end else begin
        chk("pslverr_low", 32'(PSLVERR), 32'h0);
      end
      PSEL    = !(v.drop && k != 0);
      PENABLE = (k != 0) && !v.drop;
      PWRITE  = v.wr;
      PADDR   = v.paddr;
      PWDATA  = v.pwdata;
      HREADY  = 1'b1;
      HRESP   = 1'b0;
      HRDATA  = $urandom;
      if (k >= 1 && k <= v.aw + 1) begin
        HREADY = (k == v.aw + 1);
      end else if (k >= v.aw + 2 && k <= v.aw + v.dw + 2) begin
        HREADY = (k == v.aw + v.dw + 2);
        HRESP  = v.err && (k >= v.aw + v.dw + 1);
        if (HREADY) HRDATA = v.hrdata;
      end
    end
    model_prdata = v.exp_prdata;
    exp_xfers++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK); #1;
      chk("idle_htrans", 32'(HTRANS), 32'h0);
      chk("idle_pready", 32'(PREADY), 32'h0);
      chk("idle_pslverr", 32'(PSLVERR), 32'h0);
      PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
    end
  endtask

  task automatic pulse_reset();
    #2 HRESETN = 1'b0;
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    HRESETN = 1'b1;
    model_prdata = '0;
  endtask

  task automatic reset_mid(input logic in_data);
    @(posedge HCLK); #1;
    chk("rm_setup_idle", 32'(HTRANS), 32'h0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0020; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK); #1;
    chk("rm_nonseq", 32'(HTRANS), 32'h2);
    PENABLE = 1'b1;
    HREADY  = in_data;
    if (in_data) begin
      exp_xfers++;
      @(posedge HCLK); #1;
      chk("rm_data_idle", 32'(HTRANS), 32'h0);
      HREADY = 1'b0;
    end
    pulse_reset();
    idle_cycles(3);
  endtask

  vec_t tbl [6];
  vec_t v;

  initial begin
    tbl[0] = '{1'b1, 16'h0040, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0,        1'b0, 32'h4000_0040, 3, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b0, 16'h1234, 32'h0,        0, 3, 1'b0, 32'hA5A5_5A5A, 1'b0, 32'h4000_1234, 6, 1'b0, 32'hA5A5_5A5A};
    tbl[2] = '{1'b1, 16'h0100, 32'h1111_2222, 0, 1, 1'b1, 32'h0,       1'b0, 32'h4000_0100, 4, 1'b1, 32'hA5A5_5A5A};
    tbl[3] = '{1'b0, 16'h0007, 32'h0,        2, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h4000_0004, 5, 1'b0, 32'h0BAD_F00D};
    tbl[4] = '{1'b0, 16'hFFFF, 32'h0,        1, 2, 1'b1, 32'h1234_5678, 1'b0, 32'h4000_FFFC, 6, 1'b1, 32'h0BAD_F00D};
    tbl[5] = '{1'b1, 16'h8002, 32'hCAFE_F00D, 1, 1, 1'b0, 32'h0,       1'b0, 32'h4000_8000, 5, 1'b0, 32'h0BAD_F00D};

    pulse_reset();
    chk("hsize", 32'(HSIZE), 32'h2);
    chk("hburst", 32'(HBURST), 32'h0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 32'h0);
    idle_cycles(2);

    // Vectors run back to back with PSEL held high between them.
    for (int i = 0; i < 6; i++) run_access(tbl[i]);
    idle_cycles(2);

    v = make_vec(1'b0, 16'h0300, 32'h0, 1, 1, 1'b0, 32'h7777_1111, 1'b1);
    run_access(v);
    idle_cycles(2);

    reset_mid(1'b0);
    reset_mid(1'b1);
    v = make_vec(1'b0, 16'h0044, 32'h0, 0, 0, 1'b0, 32'h3C3C_C3C3, 1'b0);
    run_access(v);

    for (int n = 0; n < 40; n++) begin
      logic err;
      int   dw;
      err = ($urandom_range(0, 3) == 0);
      dw  = err ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      v = make_vec(1'($urandom_range(0, 1)), 16'($urandom), $urandom, int'($urandom_range(0, 3)),
                   dw, err, $urandom, ($urandom_range(0, 7) == 0));
      run_access(v);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 2)));
    end
    idle_cycles(1);

    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0010; PWDATA = 32'h5555_AAAA;
    HREADY = 1'b1; HRESP = 1'b0;
`ifdef COREAPB3TOAHB_TIMEOUT_EN
    for (int k = 1; k <= TO + 1; k++) begin
      @(posedge HCLK); #1;
      chk("to_pready", 32'(PREADY), 32'(k == TO + 1));
      chk("to_htrans", 32'(HTRANS), (k == TO + 1) ? 32'h0 : 32'h2);
      if (k == TO + 1) begin
        chk("to_pslverr", 32'(PSLVERR), 32'h1);
        chk("to_prdata", PRDATA, model_prdata);
      end
      PENABLE = 1'b1; HREADY = 1'b0;
    end
    @(posedge HCLK); #1;
    chk("to_after_pready", 32'(PREADY), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRDATA = 32'hFEED_FACE;
    idle_cycles(2);
    chk("to_late_prdata", PRDATA, model_prdata);
`else
    begin : stuck
      int hi, ns;
      hi = 0; ns = 0;
      for (int k = 1; k <= 1000; k++) begin
        @(posedge HCLK); #1;
        if (PREADY === 1'b1) hi++;
        if (HTRANS === 2'b10) ns++;
        PENABLE = 1'b1; HREADY = 1'b0;
      end
      chk("stuck_pready", 32'(hi), 32'h0);
      chk("stuck_nonseq", 32'(ns), 32'd1000);
      pulse_reset();
      idle_cycles(2);
    end
`endif
    v = make_vec(1'b0, 16'h0ABC, 32'h0, 0, 1, 1'b0, 32'h1357_9BDF, 1'b0);
    run_access(v);
    idle_cycles(2);
    chk("xfer_count", 32'(xfers), 32'(exp_xfers));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
